// File: rtl/tri_rr_arb_pkg.sv
// Shared definitions for the tri_rr_arb round-robin arbiter: FSM encodings and helpers.
package tri_rr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_TURN = 2'b10
  } arb_state_e;

  localparam logic [7:0] HOLD_SAT = 8'hFF;

  function automatic int clog2_n(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/tri_rr_pick.sv
// Combinational rotate-priority picker: first set bit of vec scanning from ptr upward, wrapping mod N.
module tri_rr_pick
  import tri_rr_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [0:N-1]   vec,
  input  logic [IDW-1:0] ptr,
  output logic [0:N-1]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_pos;
  logic           w_hit;

  // Scan N positions starting at ptr; the first hit latches idx and blocks later hits.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    w_sum  = '0;
    w_pos  = '0;
    w_hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + k[IDW:0];
      w_pos = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N)) : w_sum[IDW-1:0];
      w_hit = vec[w_pos] & ~any;
      idx   = w_hit ? w_pos : idx;
      any   = any | vec[w_pos];
    end
    onehot[idx] = any;
  end

endmodule

// File: rtl/tri_rr_arb.sv
// Round-robin arbiter for one shared tri-library resource: registered one-hot grant with hold timeout.
// Optional high-priority request port enabled by defining TRI_RR_ARB_PRIO_EN.
module tri_rr_arb
  import tri_rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [0:N-1]   req,
`ifdef TRI_RR_ARB_PRIO_EN
  input  logic [0:N-1]   prio_req,
`endif
  output logic [0:N-1]   gnt,
  output logic           gnt_vld,
  output logic [0:IDW-1] gnt_id,
  output logic           hold_tmo
);

  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  arb_state_e     r_state;
  logic [IDW-1:0] r_ptr;
  logic [7:0]     r_hold_cnt;
  logic [0:N-1]   r_gnt;
  logic           r_gnt_vld;
  logic [0:IDW-1] r_gnt_id;
  logic           r_hold_tmo;
  logic           r_prio_own;

  logic [0:N-1]   w_req_oh;
  logic [IDW-1:0] w_req_idx;
  logic           w_req_any;
  logic [0:N-1]   w_win_oh;
  logic [IDW-1:0] w_win_idx;
  logic           w_win_any;
  logic           w_win_prio;
  logic           w_own_req;
  logic           w_tmo_hit;
  logic [IDW-1:0] w_next_ptr;

  tri_rr_pick #(.N(N), .IDW(IDW)) u_pick_req (
    .vec    (req),
    .ptr    (r_ptr),
    .onehot (w_req_oh),
    .idx    (w_req_idx),
    .any    (w_req_any)
  );

`ifdef TRI_RR_ARB_PRIO_EN
  logic [0:N-1]   w_prio_oh;
  logic [IDW-1:0] w_prio_idx;
  logic           w_prio_any;

  tri_rr_pick #(.N(N), .IDW(IDW)) u_pick_prio (
    .vec    (prio_req),
    .ptr    (r_ptr),
    .onehot (w_prio_oh),
    .idx    (w_prio_idx),
    .any    (w_prio_any)
  );

  // Any priority request beats every normal request; both pickers share the same pointer.
  assign w_win_oh   = w_prio_any ? w_prio_oh  : w_req_oh;
  assign w_win_idx  = w_prio_any ? w_prio_idx : w_req_idx;
  assign w_win_any  = w_prio_any | w_req_any;
  assign w_win_prio = w_prio_any;
  assign w_own_req  = req[r_gnt_id] | prio_req[r_gnt_id];
`else
  assign w_win_oh   = w_req_oh;
  assign w_win_idx  = w_req_idx;
  assign w_win_any  = w_req_any;
  assign w_win_prio = 1'b0;
  assign w_own_req  = req[r_gnt_id];
`endif

  assign w_tmo_hit  = HOLD_EN && (r_hold_cnt == HOLD_LAST) && !r_prio_own;
  assign w_next_ptr = (w_win_idx == IDW'(N - 1)) ? '0 : w_win_idx + IDW'(1);

  // Arbitration FSM with pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= '0;
      r_gnt_vld  <= 1'b0;
      r_gnt_id   <= '0;
      r_hold_tmo <= 1'b0;
      r_prio_own <= 1'b0;
    end else begin
      r_hold_tmo <= 1'b0;
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_win_any) begin
            r_state    <= ST_OWN;
            r_gnt      <= w_win_oh;
            r_gnt_vld  <= 1'b1;
            r_gnt_id   <= w_win_idx;
            r_hold_cnt <= 8'd0;
            r_ptr      <= w_next_ptr;
            r_prio_own <= w_win_prio;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (!w_own_req || w_tmo_hit) begin
            // A released or timed-out owner always passes through one dead TURN cycle.
            r_state    <= ST_TURN;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_id   <= '0;
            r_prio_own <= 1'b0;
            r_hold_tmo <= w_own_req;
          end else if (r_hold_cnt != HOLD_SAT) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end else begin
            r_hold_cnt <= HOLD_SAT;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_gnt      <= '0;
          r_gnt_vld  <= 1'b0;
          r_gnt_id   <= '0;
          r_prio_own <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign gnt_vld  = r_gnt_vld;
  assign gnt_id   = r_gnt_id;
  assign hold_tmo = r_hold_tmo;

endmodule
